pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h1C00_0000, first fetch address after reset.
REQ-002 clk  in  1  rising-edge clock, single domain.
REQ-003 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-004 stall_i  in  1  downstream (branch prediction unit / decode) cannot accept a pair.
REQ-005 flush_i  in  1  backend redirect (mispredict/exception); flush_target_i  in  32  its target.
REQ-006 bpu_taken_i  in  1  predicted-taken pulse from branch prediction unit; bpu_target_i  in  32  predicted target.
REQ-007 inst_req_o  out  1  I-cache request; inst_addr_o  out  32  request address (pc_1).
REQ-008 inst_ack_i  in  1  I-cache response; inst_1_i, inst_2_i  in  32 each  returned words.
REQ-009 pc_1_o, pc_2_o, inst_1_o, inst_2_o  out  32 each  pair delivered to branch prediction unit.
REQ-010 fetch_inst_1_en_o, fetch_inst_2_en_o  out  1 each  slot valid flags.

Function
REQ-011 FSM states: IDLE, REQ, HOLD, DROP; all outputs registered.
REQ-012 IDLE: entered on reset; next cycle -> REQ with pc = RESET_VECTOR.
REQ-013 REQ: inst_req_o=1, inst_addr_o=pc stable until inst_ack_i=1; words sampled in ack cycle.
REQ-014 On ack in REQ with stall_i=0: outputs loaded next cycle, en flags set per REQ-017, pc advances, stays REQ (new request issued cycle after ack).
REQ-015 On ack with stall_i=1: -> HOLD; pair buffered internally, en flags 0; inst_req_o=0.
REQ-016 HOLD: when stall_i falls, buffered pair presented next cycle, -> REQ.
REQ-017 Line rule: pair never crosses 16-byte line; if pc[3:2]==2'b11 only slot 1 valid (fetch_inst_2_en_o=0) and next pc = pc+4; else both valid, next pc = pc+8; pc_2_o = pc_1_o+4 always.
REQ-018 Address low bits: pc[1:0] forced 0 on every load.
REQ-019 Redirect priority: flush_i > bpu_taken_i > sequential.
REQ-020 Redirect in REQ without same-cycle ack: -> DROP, target latched; inst_req_o stays 1 with old address (request not retractable).
REQ-021 DROP: ack data discarded (en flags stay 0); next cycle -> REQ at latched target.
REQ-022 Redirect coincident with ack: returned data discarded, -> REQ at target next cycle.
REQ-023 Redirect in HOLD or IDLE: buffered pair discarded, -> REQ at target next cycle.
REQ-024 flush_i during DROP overrides latched target (including a latched bpu target).
REQ-025 Any flush_i or bpu_taken_i clears fetch_inst_1_en_o/fetch_inst_2_en_o the next cycle.
REQ-026 pc arithmetic 32-bit, wraps modulo 2^32 (32'hFFFF_FFF8+8 -> 0).

Reset
REQ-027 While rst=0: state=IDLE, inst_req_o=0, inst_addr_o=0, all pc/inst outputs 0, en flags 0, buffer cleared.
REQ-028 rst asserted mid-request: request abandoned; a later inst_ack_i in IDLE is ignored.
REQ-029 First inst_req_o with inst_addr_o=RESET_VECTOR in second cycle after rst deasserts.

Structure
REQ-030 Shared package holds InstBus width, RESET_VECTOR default, FSM state encoding, LINE_BYTES=16.
REQ-031 One sub-module natural: fetch_pair_buf (single-entry pair holding register with valid bit, used by HOLD).

Verification
REQ-032 Reset release, ack one cycle after each req, stall_i=0 -> addresses 1C000000,1C000008,1C000010; en flags both 1.
REQ-033 pc=1C00000C -> only slot 1 valid (en_2=0), next inst_addr_o=1C000010.
REQ-034 bpu_taken_i with target 1C000100 while req 1C000018 outstanding, ack 2 cycles later -> that data dropped, next req 1C000100.
REQ-035 flush_i target 1C002000 same cycle as bpu_taken_i target 1C000100 -> next req 1C002000, en flags 0 one cycle.
REQ-036 stall_i=1 for 3 cycles across ack -> pair held, no new req, pair emitted once after stall_i falls, then req pc+8.
REQ-037 rst low during outstanding req, stray ack after -> ignored; fetch restarts at 1C000000.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared definitions for the PC fetch controller.
//   INST_W           - instruction / address bus width
//   RESET_VECTOR_DEF - default first fetch address after reset
//   LINE_BYTES       - I-cache line size; a fetch pair never crosses a line
//   fetch_state_e    - fetch FSM state encoding
package pc_fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h1C00_0000;
  localparam int          LINE_BYTES       = 16;
  localparam int          LINE_OFF_W       = $clog2(LINE_BYTES);
  // Word-aligns every address that gets loaded into the pc.
  localparam logic [INST_W-1:0] ADDR_MASK  = ~32'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // True when pc is the last word of its line, so slot 2 would cross it.
  function automatic logic line_last_word(input logic [INST_W-1:0] pc);
    return &pc[LINE_OFF_W-1:2];
  endfunction

  // Sequential successor: one word at the end of a line, otherwise a pair.
  function automatic logic [INST_W-1:0] next_fetch_pc(input logic [INST_W-1:0] pc);
    return line_last_word(pc) ? pc + 32'd4 : pc + 32'd8;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pair_buf.sv
// fetch_pair_buf: single-entry holding register for a fetched pair that
// arrived while downstream was stalled.
//   clk, rst          - clock, synchronous active-low reset
//   load_i            - capture pc_i/inst_*_i/en_2_i and set valid
//   clear_i           - drop the held pair (load_i wins if both set)
//   valid_o, pc_o, inst_1_o, inst_2_o, en_2_o - held pair
module fetch_pair_buf
  import pc_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [INST_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_1_i,
  input  logic [INST_W-1:0] inst_2_i,
  input  logic              en_2_i,
  output logic              valid_o,
  output logic [INST_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_1_o,
  output logic [INST_W-1:0] inst_2_o,
  output logic              en_2_o
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_1_q, inst_1_d;
  logic [INST_W-1:0] inst_2_q, inst_2_d;
  logic              en_2_q, en_2_d;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    inst_1_d = inst_1_q;
    inst_2_d = inst_2_q;
    en_2_d   = en_2_q;
    if (load_i) begin
      valid_d  = 1'b1;
      pc_d     = pc_i;
      inst_1_d = inst_1_i;
      inst_2_d = inst_2_i;
      en_2_d   = en_2_i;
    end else if (clear_i) begin
      valid_d  = 1'b0;
      en_2_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_1_q <= '0;
      inst_2_q <= '0;
      en_2_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      inst_1_q <= inst_1_d;
      inst_2_q <= inst_2_d;
      en_2_q   <= en_2_d;
    end
  end

  assign valid_o  = valid_q;
  assign pc_o     = pc_q;
  assign inst_1_o = inst_1_q;
  assign inst_2_o = inst_2_q;
  assign en_2_o   = en_2_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage PC sequencer. Issues I-cache requests for
// instruction pairs, follows flush / predicted-taken redirects, and delivers
// pairs to the branch prediction unit. All outputs are registered.
//   clk, rst                     - clock, synchronous active-low reset
//   stall_i                      - downstream cannot take a pair
//   flush_i, flush_target_i      - backend redirect (highest priority)
//   bpu_taken_i, bpu_target_i    - predicted-taken redirect
//   inst_req_o, inst_addr_o      - I-cache request / address
//   inst_ack_i, inst_1_i/2_i     - I-cache response and data words
//   pc_1_o, pc_2_o, inst_1_o/2_o - delivered pair
//   fetch_inst_1/2_en_o          - slot valid flags (one-cycle per pair)
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [INST_W-1:0] flush_target_i,
  input  logic              bpu_taken_i,
  input  logic [INST_W-1:0] bpu_target_i,
  output logic              inst_req_o,
  output logic [INST_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [INST_W-1:0] inst_1_i,
  input  logic [INST_W-1:0] inst_2_i,
  output logic [INST_W-1:0] pc_1_o,
  output logic [INST_W-1:0] pc_2_o,
  output logic [INST_W-1:0] inst_1_o,
  output logic [INST_W-1:0] inst_2_o,
  output logic              fetch_inst_1_en_o,
  output logic              fetch_inst_2_en_o
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;       // address of the current/next request
  logic [INST_W-1:0] tgt_q, tgt_d;     // redirect target held while in DROP
  logic              req_q, req_d;
  logic [INST_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] pc_1_q, pc_1_d;
  logic [INST_W-1:0] pc_2_q, pc_2_d;
  logic [INST_W-1:0] inst_1_q, inst_1_d;
  logic [INST_W-1:0] inst_2_q, inst_2_d;
  logic              en_1_q, en_1_d;
  logic              en_2_q, en_2_d;

  logic              redir;
  logic [INST_W-1:0] redir_tgt;
  logic [INST_W-1:0] drop_tgt;
  logic [INST_W-1:0] seq_pc;
  logic              pc_last;

  logic              buf_load, buf_clear;
  logic              buf_valid, buf_en_2;
  logic [INST_W-1:0] buf_pc, buf_inst_1, buf_inst_2;

  fetch_pair_buf u_pair_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (buf_load),
    .clear_i  (buf_clear),
    .pc_i     (pc_q),
    .inst_1_i (inst_1_i),
    .inst_2_i (inst_2_i),
    .en_2_i   (!pc_last),
    .valid_o  (buf_valid),
    .pc_o     (buf_pc),
    .inst_1_o (buf_inst_1),
    .inst_2_o (buf_inst_2),
    .en_2_o   (buf_en_2)
  );

  // flush beats a same-cycle prediction: the prediction came from a path
  // the backend is throwing away.
  assign redir     = flush_i | bpu_taken_i;
  assign redir_tgt = (flush_i ? flush_target_i : bpu_target_i) & ADDR_MASK;
  // In DROP only a flush may replace the target already latched.
  assign drop_tgt  = flush_i ? (flush_target_i & ADDR_MASK) : tgt_q;
  assign pc_last   = line_last_word(pc_q);
  assign seq_pc    = next_fetch_pc(pc_q) & ADDR_MASK;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    pc_1_d    = pc_1_q;
    pc_2_d    = pc_2_q;
    inst_1_d  = inst_1_q;
    inst_2_d  = inst_2_q;
    en_1_d    = 1'b0;   // valid flags pulse once per delivered pair
    en_2_d    = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        buf_clear = 1'b1;
        pc_d      = redir ? redir_tgt : (RESET_VECTOR & ADDR_MASK);
        req_d     = 1'b1;
        addr_d    = pc_d;
        state_d   = ST_REQ;
      end

      ST_REQ: begin
        if (inst_ack_i) begin
          if (redir) begin
            // Returned words belong to the abandoned path.
            pc_d   = redir_tgt;
            addr_d = redir_tgt;
            req_d  = 1'b1;
          end else if (stall_i) begin
            buf_load = 1'b1;
            pc_d     = seq_pc;
            req_d    = 1'b0;
            state_d  = ST_HOLD;
          end else begin
            pc_1_d   = pc_q;
            pc_2_d   = pc_q + 32'd4;
            inst_1_d = inst_1_i;
            inst_2_d = inst_2_i;
            en_1_d   = 1'b1;
            en_2_d   = !pc_last;
            pc_d     = seq_pc;
            addr_d   = seq_pc;
            req_d    = 1'b1;
          end
        end else if (redir) begin
          // The cache request cannot be withdrawn: keep it up and wait for
          // its ack before switching address.
          tgt_d   = redir_tgt;
          state_d = ST_DROP;
        end
      end

      ST_HOLD: begin
        req_d = 1'b0;
        if (redir) begin
          buf_clear = 1'b1;
          pc_d      = redir_tgt;
          addr_d    = redir_tgt;
          req_d     = 1'b1;
          state_d   = ST_REQ;
        end else if (!stall_i) begin
          buf_clear = 1'b1;
          pc_1_d    = buf_pc;
          pc_2_d    = buf_pc + 32'd4;
          inst_1_d  = buf_inst_1;
          inst_2_d  = buf_inst_2;
          en_1_d    = buf_valid;
          en_2_d    = buf_valid & buf_en_2;
          addr_d    = pc_q;   // already advanced when the pair was buffered
          req_d     = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_DROP: begin
        tgt_d = drop_tgt;
        if (inst_ack_i) begin
          pc_d    = drop_tgt;
          addr_d  = drop_tgt;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      tgt_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      pc_1_q   <= '0;
      pc_2_q   <= '0;
      inst_1_q <= '0;
      inst_2_q <= '0;
      en_1_q   <= 1'b0;
      en_2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pc_1_q   <= pc_1_d;
      pc_2_q   <= pc_2_d;
      inst_1_q <= inst_1_d;
      inst_2_q <= inst_2_d;
      en_1_q   <= en_1_d;
      en_2_q   <= en_2_d;
    end
  end

  assign inst_req_o        = req_q;
  assign inst_addr_o       = addr_q;
  assign pc_1_o            = pc_1_q;
  assign pc_2_o            = pc_2_q;
  assign inst_1_o          = inst_1_q;
  assign inst_2_o          = inst_2_q;
  assign fetch_inst_1_en_o = en_1_q;
  assign fetch_inst_2_en_o = en_2_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, bpu_taken_i, inst_ack_i;
  logic [31:0] flush_target_i, bpu_target_i, inst_1_i, inst_2_i;
  logic        inst_req_o, fetch_inst_1_en_o, fetch_inst_2_en_o;
  logic [31:0] inst_addr_o, pc_1_o, pc_2_o, inst_1_o, inst_2_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        en2;
  } exp_t;
  exp_t sb[$];

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .flush_i(flush_i), .flush_target_i(flush_target_i),
    .bpu_taken_i(bpu_taken_i), .bpu_target_i(bpu_target_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_ack_i(inst_ack_i), .inst_1_i(inst_1_i), .inst_2_i(inst_2_i),
    .pc_1_o(pc_1_o), .pc_2_o(pc_2_o), .inst_1_o(inst_1_o), .inst_2_o(inst_2_o),
    .fetch_inst_1_en_o(fetch_inst_1_en_o), .fetch_inst_2_en_o(fetch_inst_2_en_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w1(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] w2(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input logic [31:0] a);
    inst_ack_i = 1'b1;
    inst_1_i   = w1(a);
    inst_2_i   = w2(a);
  endtask

  // Request at address a must be up; ack it one cycle later, expect delivery.
  task automatic do_fetch(input logic [31:0] a, input logic en2);
    exp_t e;
    chk("req_up", {31'd0, inst_req_o}, 32'd1);
    chk("req_addr", inst_addr_o, a);
    step();
    set_ack(a);
    e.pc = a; e.i1 = w1(a); e.i2 = w2(a); e.en2 = en2;
    sb.push_back(e);
    step();
    inst_ack_i = 1'b0;
  endtask

  // Scoreboard: every delivered pair must match the oldest expected one.
  always @(negedge clk) begin
    if (fetch_inst_1_en_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pair", pc_1_o, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pair_pc1", pc_1_o, e.pc);
        chk("pair_pc2", pc_2_o, e.pc + 32'd4);
        chk("pair_inst1", inst_1_o, e.i1);
        chk("pair_inst2", inst_2_o, e.i2);
        chk("pair_en2", {31'd0, fetch_inst_2_en_o}, {31'd0, e.en2});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; bpu_taken_i = 1'b0;
    inst_ack_i = 1'b0; flush_target_i = '0; bpu_target_i = '0;
    inst_1_i = '0; inst_2_i = '0;
    repeat (3) step();
    chk("rst_req", {31'd0, inst_req_o}, 32'd0);
    chk("rst_addr", inst_addr_o, 32'd0);
    chk("rst_pc1", pc_1_o, 32'd0);
    chk("rst_en", {30'd0, fetch_inst_1_en_o, fetch_inst_2_en_o}, 32'd0);

    // Reset release: first request one edge later at the reset vector.
    rst = 1'b1;
    step();
    // Sequential fetch.
    do_fetch(32'h1C00_0000, 1'b1);
    do_fetch(32'h1C00_0008, 1'b1);
    do_fetch(32'h1C00_0010, 1'b1);

    // Predicted-taken while 1C000018 outstanding; ack two cycles later.
    bpu_taken_i = 1'b1; bpu_target_i = 32'h1C00_0100;
    step();
    bpu_taken_i = 1'b0;
    chk("drop_req", {31'd0, inst_req_o}, 32'd1);
    chk("drop_addr_hold", inst_addr_o, 32'h1C00_0018);
    step();
    set_ack(32'h1C00_0018);
    step();
    inst_ack_i = 1'b0;
    chk("drop_en1", {31'd0, fetch_inst_1_en_o}, 32'd0);
    do_fetch(32'h1C00_0100, 1'b1);

    // flush + bpu + ack in one cycle: flush wins, data dropped.
    flush_i = 1'b1; flush_target_i = 32'h1C00_2000;
    bpu_taken_i = 1'b1; bpu_target_i = 32'h1C00_0100;
    set_ack(32'h1C00_0108);
    step();
    flush_i = 1'b0; bpu_taken_i = 1'b0; inst_ack_i = 1'b0;
    chk("flush_addr", inst_addr_o, 32'h1C00_2000);
    chk("flush_en", {30'd0, fetch_inst_1_en_o, fetch_inst_2_en_o}, 32'd0);

    // flush in DROP overrides latched bpu target; low bits masked.
    bpu_taken_i = 1'b1; bpu_target_i = 32'h1C00_0300;
    step();
    bpu_taken_i = 1'b0;
    flush_i = 1'b1; flush_target_i = 32'h1C00_000D;
    step();
    flush_i = 1'b0;
    chk("drop2_addr_hold", inst_addr_o, 32'h1C00_2000);
    set_ack(32'h1C00_2000);
    step();
    inst_ack_i = 1'b0;

    // Last word of line: single slot, pc+4.
    do_fetch(32'h1C00_000C, 1'b0);
    do_fetch(32'h1C00_0010, 1'b1);

    // Stall across ack for three cycles.
    stall_i = 1'b1;
    step();
    set_ack(32'h1C00_0018);
    step();
    inst_ack_i = 1'b0;
    chk("hold_req", {31'd0, inst_req_o}, 32'd0);
    step();
    chk("hold_req2", {31'd0, inst_req_o}, 32'd0);
    chk("hold_en", {31'd0, fetch_inst_1_en_o}, 32'd0);
    stall_i = 1'b0;
    sb.push_back('{pc: 32'h1C00_0018, i1: w1(32'h1C00_0018), i2: w2(32'h1C00_0018), en2: 1'b1});
    step();
    chk("release_addr", inst_addr_o, 32'h1C00_0020);
    step();
    chk("release_once", {31'd0, fetch_inst_1_en_o}, 32'd0);

    // Wrap: redirect to top of address space.
    flush_i = 1'b1; flush_target_i = 32'hFFFF_FFF8;
    set_ack(32'h1C00_0020);
    step();
    flush_i = 1'b0; inst_ack_i = 1'b0;
    do_fetch(32'hFFFF_FFF8, 1'b1);
    chk("wrap_addr", inst_addr_o, 32'h0000_0000);

    // Redirect while holding a buffered pair: pair discarded.
    stall_i = 1'b1;
    set_ack(32'h0000_0000);
    step();
    inst_ack_i = 1'b0;
    bpu_taken_i = 1'b1; bpu_target_i = 32'h1C00_0400;
    step();
    bpu_taken_i = 1'b0; stall_i = 1'b0;
    chk("hold_redir_addr", inst_addr_o, 32'h1C00_0400);
    step();
    chk("hold_redir_en", {31'd0, fetch_inst_1_en_o}, 32'd0);

    // Reset during outstanding request, stray ack afterwards.
    rst = 1'b0;
    step();
    chk("mid_rst_req", {31'd0, inst_req_o}, 32'd0);
    chk("mid_rst_addr", inst_addr_o, 32'd0);
    chk("mid_rst_inst1", inst_1_o, 32'd0);
    rst = 1'b1;
    set_ack(32'h1C00_0400);
    step();
    inst_ack_i = 1'b0;
    chk("restart_en", {31'd0, fetch_inst_1_en_o}, 32'd0);
    do_fetch(32'h1C00_0000, 1'b1);
    chk("restart_next", inst_addr_o, 32'h1C00_0008);

    step();
    step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
